// File: rtl/vec_dot_stream.sv
// Streaming signed dot-product engine: LANES element pairs per beat, accumulated over len beats.
// Build option VEC_DOT_STREAM_SAT_EN: saturate the accumulator on overflow (default: wrap).
module vec_dot_stream #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_a,
  input  logic [LANES*DATA_W-1:0]   in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_result,
  output logic                      out_ovf,
  output logic                      busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t                   state, state_d;
  logic [LEN_W-1:0]         cnt, cnt_d;
  logic                     job_clr;
  logic                     beat;

  logic signed [PROD_W-1:0] s1_prod [LANES];
  logic                     s1_valid;
  logic signed [ACC_W-1:0]  tree_sum;
  logic signed [ACC_W-1:0]  s2_sum;
  logic                     s2_valid;

  logic signed [ACC_W-1:0]  acc;
  logic                     ovf;
  logic signed [ACC_W:0]    acc_wide;
  logic                     acc_ovf;
  logic signed [ACC_W-1:0]  acc_next;

  assign beat       = in_valid && in_ready;
  assign out_result = acc;
  assign out_ovf    = ovf;

  // State, beat counter and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      in_ready  <= (state_d == RUN);
      out_valid <= (state_d == HOLD);
      busy      <= (state_d != IDLE);
    end
  end

  // Next-state logic; an empty job passes through DRAIN for one cycle so its result
  // appears one cycle after start, like a pipeline that is already empty.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    job_clr = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_d   = len;
          job_clr = 1'b1;
          state_d = (len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (beat) begin
          cnt_d = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid) state_d = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // S1: per-lane signed products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int unsigned k = 0; k < LANES; k++) s1_prod[k] <= '0;
    end else begin
      s1_valid <= beat;
      if (beat) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          s1_prod[k] <= PROD_W'($signed(in_a[k*DATA_W +: DATA_W])) *
                        PROD_W'($signed(in_b[k*DATA_W +: DATA_W]));
        end
      end
    end
  end

  // Lane sum, sign-extended to the accumulator width
  always_comb begin
    tree_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      tree_sum = tree_sum + ACC_W'(s1_prod[k]);
    end
  end

  // S2: registered lane sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_sum <= tree_sum;
    end
  end

  // S3 add with one guard bit; overflow when the guard bit disagrees with the sign bit
  always_comb begin
    acc_wide = {acc[ACC_W-1], acc} + {s2_sum[ACC_W-1], s2_sum};
    acc_ovf  = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
`ifdef VEC_DOT_STREAM_SAT_EN
    if (acc_ovf) begin
      acc_next = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_next = acc_wide[ACC_W-1:0];
    end
`else
    acc_next = acc_wide[ACC_W-1:0];
`endif
  end

  // S3: accumulator and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (job_clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (s2_valid) begin
      acc <= acc_next;
      ovf <= ovf | acc_ovf;
    end
  end

endmodule

// File: tb/tb_vec_dot_stream.sv
// Directed self-checking bench for vec_dot_stream (LANES=4, DATA_W=16, ACC_W=34).
module tb_vec_dot_stream;

  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 34;
  localparam int unsigned LEN_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_a;
  logic [LANES*DATA_W-1:0] in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        out_result;
  logic                    out_ovf;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  vec_dot_stream #(
    .LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int v0, input int v1, input int v2, input int v3);
    return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] a, input logic [63:0] b);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    check("in_ready_before_beat", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < budget) begin
      tick();
      cyc++;
    end
    check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_out_valid_low", out_valid, 0);
    check("hs_busy_low", busy, 0);
  endtask

  localparam logic signed [63:0] ACC_MAX = 64'sd8589934591;
  localparam logic signed [63:0] ACC_MIN = -64'sd8589934592;

  initial begin
    int cyc;
    logic signed [63:0] exp4, exp2;
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", $signed(out_result), 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Basic single beat: 1*5+2*6+3*7+4*8 = 70, valid 3 edges after acceptance
    start_job(1);
    check("basic_busy", busy, 1);
    send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    tick(); check("basic_lat1", out_valid, 0);
    tick(); check("basic_lat2", out_valid, 0);
    tick(); check("basic_lat3", out_valid, 1);
    check("basic_result", $signed(out_result), 70);
    check("basic_ovf", out_ovf, 0);
    handshake();

    // Three beats of 4 * (-3*7) with in_valid gaps: -252
    start_job(3);
    for (int i = 0; i < 3; i++) begin
      send_beat(pack4(-3, -3, -3, -3), pack4(7, 7, 7, 7));
      if (i < 2) begin
        check("gap_in_ready_run", in_ready, 1);
        tick();
      end
    end
    check("gap_in_ready_drain", in_ready, 0);
    wait_valid(10, cyc);
    check("gap_latency", cyc, 3);
    check("gap_result", $signed(out_result), -252);
    check("gap_in_ready_hold", in_ready, 0);

    // Back-pressure in HOLD with start pulses that must be ignored
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      len   = LEN_W'(5);
      tick();
      check("bp_result", $signed(out_result), -252);
      check("bp_out_valid", out_valid, 1);
      check("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_busy", busy, 0);
    tick();
    check("bp_start_ignored_busy", busy, 0);
    check("bp_start_ignored_ready", in_ready, 0);

    // Empty job: result 0 one cycle after start, no beats taken
    in_valid = 1'b1;
    start_job(0);
    check("empty_not_yet", out_valid, 0);
    check("empty_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    check("empty_valid", out_valid, 1);
    check("empty_result", $signed(out_result), 0);
    check("empty_ovf", out_ovf, 0);
    handshake();

    // Overflow: 16 products of 2^30 -> 2^34; wraps to 0, saturates to 2^33-1
`ifdef VEC_DOT_STREAM_SAT_EN
    exp4 = ACC_MAX;
    exp2 = ACC_MAX;
`else
    exp4 = 64'sd0;
    exp2 = ACC_MIN;
`endif
    start_job(4);
    for (int i = 0; i < 4; i++)
      send_beat(pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768));
    wait_valid(10, cyc);
    check("ovf4_result", $signed(out_result), exp4);
    check("ovf4_flag", out_ovf, 1);
    handshake();
    tick();

    // Overflow with 8 products: 2^33 wraps to -2^33
    start_job(2);
    for (int i = 0; i < 2; i++)
      send_beat(pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768));
    wait_valid(10, cyc);
    check("ovf2_result", $signed(out_result), exp2);
    check("ovf2_flag", out_ovf, 1);
    handshake();
    tick();

    // Reset in RUN with 2 beats left, then a clean len=1 job
    start_job(4);
    send_beat(pack4(1000, 1000, 1000, 1000), pack4(900, 900, 900, 900));
    send_beat(pack4(-500, 7, 7, 7), pack4(300, 3, 3, 3));
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", $signed(out_result), 0);
    check("midrst_ovf", out_ovf, 0);
    check("midrst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start_job(1);
    send_beat(pack4(1, -2, 3, -4), pack4(5, 6, 7, 8));
    wait_valid(10, cyc);
    check("post_rst_latency", cyc, 3);
    check("post_rst_result", $signed(out_result), -18);
    check("post_rst_ovf", out_ovf, 0);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
